// File: rtl/i2c_slave_ctrl.sv
// I2C target byte engine: filtered SCL/SDA sampling, START/STOP detection,
// 7-bit address match with ACK, byte delivery on writes and byte fetch on reads.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         GLITCH_LEN = 3
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       nack_rcvd,
  output logic       rw,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  localparam int CW = $clog2(GLITCH_LEN + 1);
  localparam logic [CW-1:0] GL_M1 = CW'(GLITCH_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK
  } state_t;

  logic          scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic          scl_p_q, sda_p_q;
  logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          done_q, done_d;
  logic          mack_q, mack_d;
  logic          rw_q, rw_d;
  logic          busy_q, busy_d;
  logic          oen_q, oen_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          tx_req_q, tx_req_d;
  logic          nack_q, nack_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_ev, stop_ev;

  // A filtered level only follows the synchronized pad after GLITCH_LEN
  // consecutive differing samples; any agreeing sample restarts the count.
  always_comb begin
    scl_f_d   = scl_f_q;
    scl_cnt_d = '0;
    if (scl_s2_q != scl_f_q) begin
      if (scl_cnt_q == GL_M1) scl_f_d = scl_s2_q;
      else                    scl_cnt_d = scl_cnt_q + 1'b1;
    end
    sda_f_d   = sda_f_q;
    sda_cnt_d = '0;
    if (sda_s2_q != sda_f_q) begin
      if (sda_cnt_q == GL_M1) sda_f_d = sda_s2_q;
      else                    sda_cnt_d = sda_cnt_q + 1'b1;
    end
  end

  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign sda_rise = sda_f_q & ~sda_p_q;
  assign sda_fall = ~sda_f_q & sda_p_q;
  assign start_ev = sda_fall & scl_f_q;
  assign stop_ev  = sda_rise & scl_f_q;

  // Read handshake: tx_req pulses once per byte; local logic must hold the
  // byte on tx_data from that pulse until the following SCL fall loads it.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    mack_d     = mack_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    oen_d      = oen_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    nack_d     = 1'b0;
    start_d    = start_ev;
    stop_d     = stop_ev;
    if (stop_ev) begin
      state_d = S_IDLE;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (start_ev) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      done_d    = 1'b0;
      oen_d     = 1'b1;
    end else begin
      case (state_q)
        S_ADDR, S_WRITE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (state_q == S_WRITE) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              oen_d      = 1'b0;
              state_d    = S_WRITE_ACK;
            end else if (shift_q[7:1] == SLAVE_ADDR && shift_q[7:1] != 7'd0) begin
              rw_d    = shift_q[0];
              busy_d  = 1'b1;
              oen_d   = 1'b0;
              state_d = S_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              oen_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise) begin
            tx_req_d = rw_q;
          end else if (scl_fall) begin
            oen_d   = 1'b1;
            state_d = S_WRITE;
            if (rw_q) begin
              shift_d = tx_data;
              oen_d   = tx_data[7];
              state_d = S_READ;
            end
          end
        end
        S_WRITE_ACK: begin
          if (scl_fall) begin
            oen_d   = 1'b1;
            state_d = S_WRITE;
          end
        end
        S_READ: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall) begin
            if (done_q) begin
              done_d  = 1'b0;
              oen_d   = 1'b1;
              state_d = S_READ_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oen_d   = shift_q[6];
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise) begin
            mack_d   = ~sda_f_q;
            tx_req_d = ~sda_f_q;
            nack_d   = sda_f_q;
          end else if (scl_fall) begin
            if (mack_q) begin
              shift_d = tx_data;
              oen_d   = tx_data[7];
              state_d = S_READ;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      done_q     <= 1'b0;
      mack_q     <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      oen_q      <= 1'b1;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      nack_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_s1_q   <= scl_pad_i;
      scl_s2_q   <= scl_s1_q;
      sda_s1_q   <= sda_pad_i;
      sda_s2_q   <= sda_s1_q;
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_p_q    <= scl_f_q;
      sda_p_q    <= sda_f_q;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      mack_q     <= mack_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      oen_q      <= oen_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      nack_q     <= nack_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_pad_o    = 1'b0;
  assign scl_padoen_o = 1'b1;
  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_req       = tx_req_q;
  assign nack_rcvd    = nack_q;
  assign rw           = rw_q;
  assign busy         = busy_q;
  assign start_det    = start_q;
  assign stop_det     = stop_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: the bench plays the bus master and
// checks ACKs, returned read bits, event pulses and status outputs.
module tb_i2c_slave_ctrl;
  localparam int GL = 3;

  logic       wb_clk_i = 1'b0;
  logic       arst_i   = 1'b0;
  logic       m_scl    = 1'b1;
  logic       m_sda    = 1'b1;
  logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, nack_rcvd, rw, busy, start_det, stop_det;
  logic [7:0] tx_data = 8'h00;
  logic       sda_bus;

  int n_cmp = 0;
  int n_err = 0;
  int n_rxv = 0, n_txr = 0, n_nack = 0, n_start = 0, n_stop = 0;
  int n_oen_low = 0, n_busy = 0;
  int tx_idx = 0;
  logic [7:0] tx_tbl [5] = '{8'hA5, 8'h0F, 8'h96, 8'h40, 8'h00};

  assign sda_bus = m_sda & (sda_padoen_o ? 1'b1 : sda_pad_o);

  always #5 wb_clk_i = ~wb_clk_i;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .GLITCH_LEN(GL)) dut (
    .wb_clk_i(wb_clk_i), .arst_i(arst_i),
    .scl_pad_i(m_scl), .sda_pad_i(sda_bus),
    .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
    .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .nack_rcvd(nack_rcvd),
    .rw(rw), .busy(busy), .start_det(start_det), .stop_det(stop_det)
  );

  // Pulse counters and the local-logic side of the read handshake.
  always @(posedge wb_clk_i) begin
    #1;
    if (rx_valid)      n_rxv++;
    if (nack_rcvd)     n_nack++;
    if (start_det)     n_start++;
    if (stop_det)      n_stop++;
    if (!sda_padoen_o) n_oen_low++;
    if (busy)          n_busy++;
    if (tx_req) begin
      n_txr++;
      if (tx_idx < 5) tx_data = tx_tbl[tx_idx];
      tx_idx++;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic bus_bit(input logic b, input logic glitch, output logic s);
    m_sda = b;
    wait_clk(10);
    m_scl = 1'b1;
    if (glitch) begin
      wait_clk(4);
      m_scl = 1'b0;
      wait_clk(GL - 1);
      m_scl = 1'b1;
      wait_clk(10 - 4 - (GL - 1));
    end else begin
      wait_clk(10);
    end
    s = sda_bus;
    wait_clk(10);
    m_scl = 1'b0;
    wait_clk(10);
  endtask

  task automatic bus_start;
    m_sda = 1'b1; m_scl = 1'b1;
    wait_clk(10);
    m_sda = 1'b0;
    wait_clk(20);
    m_scl = 1'b0;
    wait_clk(10);
  endtask

  task automatic bus_rstart;
    m_sda = 1'b1;
    wait_clk(10);
    m_scl = 1'b1;
    wait_clk(20);
    m_sda = 1'b0;
    wait_clk(20);
    m_scl = 1'b0;
    wait_clk(10);
  endtask

  task automatic bus_stop;
    m_sda = 1'b0;
    wait_clk(10);
    m_scl = 1'b1;
    wait_clk(20);
    m_sda = 1'b1;
    wait_clk(20);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], (i == glitch_bit), s);
    bus_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    bus_bit(mack, 1'b0, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rd;
    int b_rxv, b_txr, b_nack, b_start, b_stop, b_oen, b_busy;

    // Reset state
    wait_clk(3);
    #1;
    chk("reset_pads", {12'd0, scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o}, 16'h0005);
    chk("reset_rx_data", {8'd0, rx_data}, 16'h0000);
    chk("reset_flags", {9'd0, rx_valid, tx_req, nack_rcvd, rw, busy, start_det, stop_det}, 16'h0000);
    arst_i = 1'b1;
    wait_clk(10);

    // 1: write 0x3C
    b_rxv = n_rxv; b_stop = n_stop;
    bus_start();
    write_byte(8'hA0, -1, ack);
    chk("t1_addr_ack", {15'd0, ack}, 16'h0000);
    chk("t1_busy_on", {15'd0, busy}, 16'h0001);
    write_byte(8'h3C, -1, ack);
    chk("t1_data_ack", {15'd0, ack}, 16'h0000);
    chk("t1_rx_data", {8'd0, rx_data}, 16'h003C);
    chk("t1_rx_valid_cnt", 16'(n_rxv - b_rxv), 16'd1);
    chk("t1_busy_pre_stop", {15'd0, busy}, 16'h0001);
    bus_stop();
    chk("t1_busy_post_stop", {15'd0, busy}, 16'h0000);
    chk("t1_stop_cnt", 16'(n_stop - b_stop), 16'd1);

    // 2: address mismatch
    b_rxv = n_rxv; b_oen = n_oen_low; b_busy = n_busy;
    bus_start();
    write_byte(8'hA4, -1, ack);
    chk("t2_addr_nack", {15'd0, ack}, 16'h0001);
    write_byte(8'h11, -1, ack);
    chk("t2_data_nack", {15'd0, ack}, 16'h0001);
    bus_stop();
    chk("t2_oen_low_cycles", 16'(n_oen_low - b_oen), 16'd0);
    chk("t2_rx_valid_cnt", 16'(n_rxv - b_rxv), 16'd0);
    chk("t2_busy_cycles", 16'(n_busy - b_busy), 16'd0);

    // 3: read two bytes, ACK then NACK
    b_txr = n_txr; b_nack = n_nack;
    bus_start();
    write_byte(8'hA1, -1, ack);
    chk("t3_addr_ack", {15'd0, ack}, 16'h0000);
    chk("t3_rw", {15'd0, rw}, 16'h0001);
    read_byte(1'b0, rd);
    chk("t3_byte1", {8'd0, rd}, 16'h00A5);
    read_byte(1'b1, rd);
    chk("t3_byte2", {8'd0, rd}, 16'h000F);
    chk("t3_tx_req_cnt", 16'(n_txr - b_txr), 16'd2);
    chk("t3_nack_cnt", 16'(n_nack - b_nack), 16'd1);
    chk("t3_sda_released", {15'd0, sda_padoen_o}, 16'h0001);
    chk("t3_busy_after_nack", {15'd0, busy}, 16'h0001);
    bus_stop();
    chk("t3_busy_post_stop", {15'd0, busy}, 16'h0000);

    // 4: write, repeated START, read
    b_start = n_start; b_busy = n_busy;
    bus_start();
    write_byte(8'hA0, -1, ack);
    chk("t4_addr_w_ack", {15'd0, ack}, 16'h0000);
    chk("t4_rw_write", {15'd0, rw}, 16'h0000);
    write_byte(8'h10, -1, ack);
    chk("t4_data_ack", {15'd0, ack}, 16'h0000);
    bus_rstart();
    chk("t4_busy_at_sr", {15'd0, busy}, 16'h0001);
    write_byte(8'hA1, -1, ack);
    chk("t4_addr_r_ack", {15'd0, ack}, 16'h0000);
    chk("t4_rw_read", {15'd0, rw}, 16'h0001);
    read_byte(1'b1, rd);
    chk("t4_read_byte", {8'd0, rd}, 16'h0096);
    chk("t4_busy_pre_stop", {15'd0, busy}, 16'h0001);
    bus_stop();
    chk("t4_start_cnt", 16'(n_start - b_start), 16'd2);
    chk("t4_rx_data", {8'd0, rx_data}, 16'h0010);
    chk("t4_busy_post_stop", {15'd0, busy}, 16'h0000);

    // 5: short SCL glitch inside a data bit
    b_rxv = n_rxv;
    bus_start();
    write_byte(8'hA0, -1, ack);
    chk("t5_addr_ack", {15'd0, ack}, 16'h0000);
    write_byte(8'h3C, 4, ack);
    chk("t5_data_ack", {15'd0, ack}, 16'h0000);
    chk("t5_rx_data", {8'd0, rx_data}, 16'h003C);
    chk("t5_rx_valid_cnt", 16'(n_rxv - b_rxv), 16'd1);
    bus_stop();

    // 6: reset while the target pulls SDA low during a read
    bus_start();
    write_byte(8'hA1, -1, ack);
    chk("t6_addr_ack", {15'd0, ack}, 16'h0000);
    bus_bit(1'b1, 1'b0, s);
    chk("t6_bit7", {15'd0, s}, 16'h0000);
    bus_bit(1'b1, 1'b0, s);
    chk("t6_bit6", {15'd0, s}, 16'h0001);
    chk("t6_driving_low", {15'd0, sda_padoen_o}, 16'h0000);
    arst_i = 1'b0;
    #1;
    chk("t6_oen_async", {15'd0, sda_padoen_o}, 16'h0001);
    chk("t6_busy_reset", {15'd0, busy}, 16'h0000);
    wait_clk(3);
    arst_i = 1'b1;
    b_oen = n_oen_low;
    for (int i = 0; i < 7; i++) bus_bit(1'b1, 1'b0, s);
    chk("t6_ignored_bits", 16'(n_oen_low - b_oen), 16'd0);
    bus_rstart();
    write_byte(8'hA0, -1, ack);
    chk("t6_readdress_ack", {15'd0, ack}, 16'h0000);
    chk("t6_busy_again", {15'd0, busy}, 16'h0001);
    bus_stop();
    chk("t6_busy_post_stop", {15'd0, busy}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
